// File: rtl/mesm6_mem_arbiter.sv
// Arbitrates the MESM-6 instruction-fetch and data buses onto one single-port
// 48-bit word memory; registered outputs, one-cycle done, timeout abort.
module mesm6_mem_arbiter #(
    parameter int unsigned FAIR    = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ibus_fetch,
    input  logic [14:0] ibus_addr,
    output logic [47:0] ibus_input,
    output logic        ibus_done,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [14:0] dbus_addr,
    input  logic [47:0] dbus_output,
    output logic [47:0] dbus_input,
    output logic        dbus_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [47:0] mem_wdata,
    input  logic [47:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_error
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic        FAIR_EN = (FAIR != 0);
    localparam logic        TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;          // 1 = dbus owns the current access
    logic        last_q, last_d;        // 1 = dbus was granted last
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [14:0] addr_q, addr_d;
    logic [47:0] wdata_q, wdata_d;
    logic        idone_q, idone_d;
    logic        ddone_q, ddone_d;
    logic        err_q, err_d;
    logic [47:0] iin_q, iin_d;
    logic [47:0] din_q, din_d;

    logic        pend_i, pend_d, pick_d, expire;
    logic [47:0] rd_val;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        idone_d = 1'b0;
        ddone_d = 1'b0;
        err_d   = 1'b0;
        iin_d   = iin_q;
        din_d   = din_q;

        pend_i = ibus_fetch;
        pend_d = dbus_read | dbus_write;
        // dbus wins unless both pend under fair mode and dbus had the last grant
        pick_d = pend_d & ~(pend_i & FAIR_EN & last_q);
        expire = TO_EN & (cnt_q == TO_LAST);
        rd_val = mem_ack ? mem_rdata : '0;

        unique case (state_q)
            S_IDLE: begin
                if (pend_i | pend_d) begin
                    gnt_d   = pick_d;
                    addr_d  = pick_d ? dbus_addr : ibus_addr;
                    we_d    = pick_d & dbus_write;
                    if (pick_d & dbus_write)
                        wdata_d = dbus_output;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack | expire) begin
                    req_d   = 1'b0;
                    err_d   = ~mem_ack;
                    idone_d = ~gnt_q;
                    ddone_d = gnt_q;
                    if (!we_q) begin
                        if (gnt_q) din_d = rd_val;
                        else       iin_d = rd_val;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                last_d  = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idone_q <= 1'b0;
            ddone_q <= 1'b0;
            err_q   <= 1'b0;
            iin_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idone_q <= idone_d;
            ddone_q <= ddone_d;
            err_q   <= err_d;
            iin_q   <= iin_d;
            din_q   <= din_d;
        end
    end

    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign ibus_done  = idone_q;
    assign dbus_done  = ddone_q;
    assign bus_error  = err_q;
    assign ibus_input = iin_q;
    assign dbus_input = din_q;

endmodule
